// File: rtl/multdiv_pkg.sv
// Shared types, constants and helpers for the iterative multiply/divide unit.
package multdiv_pkg;

  localparam int ITER = 32;
  localparam int CNT_W = 5;
  localparam logic [ITER-1:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_e;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_e;

  // Two's-complement magnitude as unsigned; INT_MIN maps onto itself.
  function automatic logic [ITER-1:0] abs32(input logic [ITER-1:0] x);
    return x[ITER-1] ? (~x + 1'b1) : x;
  endfunction

  // 8-bit carry-lookahead slice: generate/propagate per bit, carries
  // resolved inside the slice, returns {carry_out, sum}.
  function automatic logic [8:0] cla8(input logic [7:0] a,
                                      input logic [7:0] b,
                                      input logic       cin);
    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return {c[8], p ^ c[7:0]};
  endfunction

endpackage

// File: rtl/multdiv_step.sv
// One iteration of the multiply/divide datapath: a single 33-bit add or
// subtract built from chained 8-bit CLA slices.
module multdiv_step
  import multdiv_pkg::*;
(
  input  op_e                 op,
  input  logic [2*ITER-1:0]   acc,
  input  logic [ITER-1:0]     opnd,
  output logic [2*ITER-1:0]   acc_next,
  output logic                q_bit
);

  logic [ITER:0] add_a;
  logic [ITER:0] add_b;
  logic          add_cin;
  logic [ITER:0] add_sum;
  logic          add_cout;

  // Operand selection: multiply adds |A| to the upper product half, divide
  // subtracts |B| from the shifted partial remainder (a + ~b + 1).
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the if/else can leave it unassigned and infer a latch.
    add_a   = {1'b0, acc[2*ITER-1:ITER]};
    add_b   = {1'b0, opnd};
    add_cin = 1'b0;
    if (op == OP_DIV) begin
      add_a   = acc[2*ITER-1:ITER-1];
      add_b   = ~{1'b0, opnd};
      add_cin = 1'b1;
    end
  end

  // Four CLA slices give bits 31:0; bit 32 closes the chain and yields the
  // carry out that the divider uses as its "no borrow" quotient bit.
  always_comb begin : adder_chain
    logic [8:0] slice;
    logic       c;
    add_sum  = '0;
    c        = add_cin;
    for (int s = 0; s < 4; s++) begin
      slice            = cla8(add_a[8*s +: 8], add_b[8*s +: 8], c);
      add_sum[8*s +: 8] = slice[7:0];
      c                = slice[8];
    end
    add_sum[ITER] = add_a[ITER] ^ add_b[ITER] ^ c;
    add_cout      = (add_a[ITER] & add_b[ITER]) | ((add_a[ITER] ^ add_b[ITER]) & c);
  end

  // Next accumulator: shift-add for multiply, restoring step for divide.
  always_comb begin
    acc_next = acc;
    q_bit    = 1'b0;
    if (op == OP_MUL) begin
      if (acc[0]) begin
        acc_next = {add_sum, acc[ITER-1:1]};
      end else begin
        acc_next = {1'b0, acc[2*ITER-1:ITER], acc[ITER-1:1]};
      end
    end else begin
      q_bit                   = add_cout;
      acc_next[2*ITER-1:ITER] = add_cout ? add_sum[ITER-1:0] : acc[2*ITER-2:ITER-1];
      acc_next[ITER-1:0]      = {acc[ITER-2:0], add_cout};
    end
  end

endmodule

// File: rtl/multdiv_iter.sv
// Iterative signed 32-bit multiply/divide unit: captures an op while idle,
// runs ITER single-add iterations on the magnitudes, then applies sign and
// exception fix-up and presents a registered result with a one-cycle ready.
module multdiv_iter
  import multdiv_pkg::*;
(
  input  logic            clock,
  input  logic            resetn,
  input  logic [ITER-1:0] data_operandA,
  input  logic [ITER-1:0] data_operandB,
  input  logic            ctrl_MULT,
  input  logic            ctrl_DIV,
  output logic [ITER-1:0] data_result,
  output logic            data_exception,
  output logic            data_resultRDY,
  output logic            busy
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);

  state_e            state;
  op_e               op;
  logic [CNT_W-1:0]  cnt;
  logic              neg_res;
  logic              div_zero;
  logic              div_ovf;
  logic [ITER-1:0]   opnd;
  logic [2*ITER-1:0] acc;
  logic [2*ITER-1:0] acc_next;
  logic              q_bit_unused;

  logic [ITER-1:0]   mag_a;
  logic [ITER-1:0]   mag_b;
  logic [2*ITER-1:0] prod;
  logic [ITER-1:0]   quot;
  logic [ITER-1:0]   fix_res;
  logic              fix_exc;

  assign mag_a = abs32(data_operandA);
  assign mag_b = abs32(data_operandB);

  multdiv_step u_step (
    .op       (op),
    .acc      (acc),
    .opnd     (opnd),
    .acc_next (acc_next),
    .q_bit    (q_bit_unused)
  );

  // Completion fix-up: restore the sign and flag results that do not fit.
  always_comb begin
    prod    = neg_res ? (~acc + 64'd1) : acc;
    quot    = neg_res ? (~acc[ITER-1:0] + 32'd1) : acc[ITER-1:0];
    fix_res = prod[ITER-1:0];
    fix_exc = !((&prod[2*ITER-1:ITER-1]) || !(|prod[2*ITER-1:ITER-1]));
    if (op == OP_DIV) begin
      if (div_zero) begin
        fix_res = '0;
        fix_exc = 1'b1;
      end else if (div_ovf) begin
        fix_res = INT_MIN;
        fix_exc = 1'b1;
      end else begin
        fix_res = quot;
        fix_exc = 1'b0;
      end
    end
  end

  // Control FSM, iteration counter, operand registers and output registers.
  always_ff @(posedge clock or negedge resetn) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!resetn) begin
      state          <= IDLE;
      op             <= OP_MUL;
      cnt            <= '0;
      neg_res        <= 1'b0;
      div_zero       <= 1'b0;
      div_ovf        <= 1'b0;
      opnd           <= '0;
      acc            <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      case (state)
        IDLE: begin
          if (ctrl_MULT || ctrl_DIV) begin
            state    <= RUN;
            busy     <= 1'b1;
            cnt      <= '0;
            neg_res  <= data_operandA[ITER-1] ^ data_operandB[ITER-1];
            div_zero <= (data_operandB == '0);
            div_ovf  <= (data_operandA == INT_MIN) && (data_operandB == '1);
            if (ctrl_MULT) begin
              op   <= OP_MUL;
              opnd <= mag_a;
              acc  <= {{ITER{1'b0}}, mag_b};
            end else begin
              op   <= OP_DIV;
              opnd <= mag_b;
              acc  <= {{ITER{1'b0}}, mag_a};
            end
          end
        end
        RUN: begin
          acc <= acc_next;
          if (cnt == LAST_ITER) begin
            state <= FIX;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIX: begin
          data_result    <= fix_res;
          data_exception <= fix_exc;
          data_resultRDY <= 1'b1;
          busy           <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_iter.sv
// Self-checking bench for multdiv_iter: a timeline model predicts busy, ready,
// result and exception every cycle; directed ops pin literal expectations.
module tb_multdiv_iter;

  logic        clock = 1'b0;
  logic        resetn;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  multdiv_iter dut (
    .clock          (clock),
    .resetn         (resetn),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference: {exception, result} from plain signed arithmetic.
  function automatic logic [32:0] ref_model(input logic is_div, input logic [31:0] a,
                                            input logic [31:0] b);
    longint p;
    int     q;
    if (!is_div) begin
      p = longint'($signed(a)) * longint'($signed(b));
      return {p != longint'($signed(p[31:0])), p[31:0]};
    end
    if (b == 32'h0) return {1'b1, 32'h0};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
    q = $signed(a) / $signed(b);
    return {1'b0, 32'(q)};
  endfunction

  // Timeline model: an accepted op completes ITER+1 edges after capture.
  int          m_left = -1;
  logic        m_rdy  = 1'b0;
  logic [31:0] m_res  = 32'h0;
  logic        m_exc  = 1'b0;
  logic [32:0] m_pend = 33'h0;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_left <= -1;
      m_rdy  <= 1'b0;
      m_res  <= 32'h0;
      m_exc  <= 1'b0;
    end else begin
      m_rdy <= 1'b0;
      if (m_left < 0) begin
        if (ctrl_MULT || ctrl_DIV) begin
          m_left <= 33;
          m_pend <= ref_model(!ctrl_MULT, data_operandA, data_operandB);
        end
      end else if (m_left == 1) begin
        m_left <= -1;
        m_rdy  <= 1'b1;
        m_res  <= m_pend[31:0];
        m_exc  <= m_pend[32];
      end else begin
        m_left <= m_left - 1;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clock) begin
    if (check_en) begin
      check("busy", 32'(busy), 32'(m_left >= 0));
      check("rdy", 32'(data_resultRDY), 32'(m_rdy));
      check("result", data_result, m_res);
      check("exception", 32'(data_exception), 32'(m_exc));
      check("busy_rdy_exclusive", 32'(busy & data_resultRDY), 32'h0);
    end
  end

  task automatic run_op(input string name, input logic mul, input logic div,
                        input logic [31:0] opa, input logic [31:0] opb,
                        input logic [31:0] exp_res, input logic exp_exc,
                        input int stray_at);
    logic [32:0] r;
    int          lat;
    bit          got;
    r = ref_model(div && !mul, opa, opb);
    check({name, "_model_res"}, r[31:0], exp_res);
    check({name, "_model_exc"}, 32'(r[32]), 32'(exp_exc));
    @(negedge clock);
    data_operandA = opa;
    data_operandB = opb;
    ctrl_MULT     = mul;
    ctrl_DIV      = div;
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = 32'hDEAD_BEEF;
    data_operandB = 32'h0BAD_F00D;
    got = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge clock);
      ctrl_MULT = (i == stray_at);
      if (data_resultRDY) begin
        got = 1'b1;
        lat = i;
      end
    end
    ctrl_MULT = 1'b0;
    check({name, "_latency"}, 32'(lat), 32'd33);
    check({name, "_result"}, data_result, exp_res);
    check({name, "_exc"}, 32'(data_exception), 32'(exp_exc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rdy_seen;
    resetn        = 1'b0;
    data_operandA = 32'h0;
    data_operandB = 32'h0;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    repeat (3) @(negedge clock);
    resetn   = 1'b1;
    check_en = 1'b1;

    check("reset_busy", 32'(busy), 32'h0);
    check("reset_rdy", 32'(data_resultRDY), 32'h0);
    check("reset_result", data_result, 32'h0);
    check("reset_exc", 32'(data_exception), 32'h0);

    run_op("mul_7_m3",      1, 0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, -1);
    run_op("mul_ovf",       1, 0, 32'h0001_0000, 32'h0000_8000, 32'h8000_0000, 1, -1);
    run_op("mul_min_1",     1, 0, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 0, -1);
    run_op("div_m7_2",      0, 1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 0, -1);
    run_op("div_100_0",     0, 1, 32'h0000_0064, 32'h0000_0000, 32'h0000_0000, 1, -1);
    run_op("div_min_m1",    0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, -1);
    run_op("div_min_2",     0, 1, 32'h8000_0000, 32'h0000_0002, 32'hC000_0000, 0, -1);
    run_op("div_9_4_stray", 0, 1, 32'h0000_0009, 32'h0000_0004, 32'h0000_0002, 0, 4);
    run_op("both_6_3",      1, 1, 32'h0000_0006, 32'h0000_0003, 32'h0000_0012, 0, -1);
    run_op("div_m20_m3",    0, 1, 32'hFFFF_FFEC, 32'hFFFF_FFFD, 32'h0000_0006, 0, -1);

    // Reset in the middle of RUN aborts the op without a ready pulse.
    @(negedge clock);
    data_operandA = 32'h0000_0007;
    data_operandB = 32'h0000_0009;
    ctrl_MULT     = 1'b1;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    repeat (10) @(negedge clock);
    #2 resetn = 1'b0;
    @(negedge clock);
    check("midreset_busy", 32'(busy), 32'h0);
    check("midreset_result", data_result, 32'h0);
    check("midreset_rdy", 32'(data_resultRDY), 32'h0);
    resetn   = 1'b1;
    rdy_seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY) rdy_seen++;
    end
    check("midreset_no_rdy", 32'(rdy_seen), 32'h0);
    run_op("mul_5_5", 1, 0, 32'h0000_0005, 32'h0000_0005, 32'h0000_0019, 0, -1);

    // Idle with both controls low never produces a ready pulse.
    rdy_seen = 0;
    repeat (50) begin
      @(negedge clock);
      if (data_resultRDY) rdy_seen++;
    end
    check("idle_no_rdy", 32'(rdy_seen), 32'h0);
    check("idle_result_hold", data_result, 32'h0000_0019);

    repeat (3) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
